// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder; slave = adder side, master = driver side.
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic                    valid_i;
  logic                    ready_o;
  logic signed [WIDTH-1:0] src1_i;
  logic signed [WIDTH-1:0] src2_i;
  logic                    sub_i;
  logic                    valid_o;
  logic                    ready_i;
  logic signed [WIDTH-1:0] sum_o;
  logic                    carry_o;
  logic                    overflow_o;
  logic                    zero_o;

  modport slave (
    input  valid_i, src1_i, src2_i, sub_i, ready_i,
    output ready_o, valid_o, sum_o, carry_o, overflow_o, zero_o
  );

  modport master (
    output valid_i, src1_i, src2_i, sub_i, ready_i,
    input  ready_o, valid_o, sum_o, carry_o, overflow_o, zero_o
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined two's-complement add/sub; the carry ripples one CW-bit chunk per stage.
// Define PIPE_ADDER_SAT_EN to clamp the result on signed overflow.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  pipe_adder_if.slave bus
);
  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  typedef logic [WIDTH-1:0] word_t;

  // sa_p[k]: sum chunks 0..k in place, A chunks above them still waiting to be added
  word_t sa_p  [STAGES];
  word_t b_p   [STAGES];
  logic  c_p   [STAGES];
  logic  vld_p [STAGES];
  logic  ovf_p;
  logic  zero_p;

  word_t sa_nx [STAGES];
  word_t b_nx  [STAGES];
  logic  c_nx  [STAGES];
  logic  v_nx  [STAGES];
  logic  ovf_nx;
  logic  zero_nx;
  logic  adv;

`ifdef PIPE_ADDER_SAT_EN
  function automatic word_t sat_word(input word_t s, input logic a_neg, input logic ovf);
    word_t lim;
    lim = {a_neg, {(WIDTH-1){~a_neg}}};
    return ovf ? lim : s;
  endfunction
`endif

  assign adv         = bus.ready_i || !vld_p[LAST];
  assign bus.ready_o = adv;

  always_comb begin
    word_t       sa_in;
    word_t       b_in;
    logic        c_in;
    logic        a_msb;
    logic        b_msb;
    logic [CW:0] part;
    int          pk;
    a_msb   = 1'b0;
    b_msb   = 1'b0;
    ovf_nx  = 1'b0;
    zero_nx = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      pk = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        sa_in   = bus.src1_i;
        b_in    = bus.sub_i ? ~bus.src2_i : bus.src2_i;
        c_in    = bus.sub_i;
        v_nx[k] = bus.valid_i;
      end else begin
        sa_in   = sa_p[pk];
        b_in    = b_p[pk];
        c_in    = c_p[pk];
        v_nx[k] = vld_p[pk];
      end
      // B' is kept pre-shifted, so its next chunk always sits at the bottom
      part = {1'b0, sa_in[k*CW +: CW]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};
      sa_nx[k]              = sa_in;
      sa_nx[k][k*CW +: CW]  = part[CW-1:0];
      b_nx[k]               = b_in >> CW;
      c_nx[k]               = part[CW];
      if (k == LAST) begin
        a_msb = sa_in[WIDTH-1];
        b_msb = b_in[CW-1];
      end
    end
    ovf_nx = (a_msb == b_msb) && (sa_nx[LAST][WIDTH-1] != a_msb);
`ifdef PIPE_ADDER_SAT_EN
    sa_nx[LAST] = sat_word(sa_nx[LAST], a_msb, ovf_nx);
`endif
    zero_nx = (sa_nx[LAST] == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        sa_p[k]  <= '0;
        b_p[k]   <= '0;
        c_p[k]   <= 1'b0;
        vld_p[k] <= 1'b0;
      end
      ovf_p  <= 1'b0;
      zero_p <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        sa_p[k]  <= sa_nx[k];
        b_p[k]   <= b_nx[k];
        c_p[k]   <= c_nx[k];
        vld_p[k] <= v_nx[k];
      end
      ovf_p  <= ovf_nx;
      zero_p <= zero_nx;
    end
  end

  // last stage registers drive the result port directly
  assign bus.valid_o    = vld_p[LAST];
  assign bus.sum_o      = sa_p[LAST];
  assign bus.carry_o    = c_p[LAST];
  assign bus.overflow_o = ovf_p;
  assign bus.zero_o     = zero_p;
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: 32-bit/4-stage and 8-bit/1-stage instances.
`timescale 1ns/1ps
module tb_pipe_adder;
  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_adder_if #(.WIDTH(32)) bus32 ();
  pipe_adder_if #(.WIDTH(8))  bus8 ();

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (.clk_i(clk), .rst_i(rst_i), .bus(bus32));
  pipe_adder #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clk_i(clk), .rst_i(rst_i), .bus(bus8));

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [31:0] OVF_P32 = 32'h7FFF_FFFF;
  localparam logic [31:0] OVF_N32 = 32'h8000_0000;
  localparam logic [31:0] OVF_P8  = 32'h0000_007F;
`else
  localparam logic [31:0] OVF_P32 = 32'h8000_0000;
  localparam logic [31:0] OVF_N32 = 32'h7FFF_FFFF;
  localparam logic [31:0] OVF_P8  = 32'h0000_0080;
`endif

  res_t q32[$];
  res_t q8[$];
  int checks = 0;
  int errors = 0;
  int n_pop32 = 0, n_pop8 = 0;
  int first_pop32 = 0, last_pop32 = 0, last_pop8 = 0, last_acc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic res_t mk(input logic [31:0] s, input logic c, input logic o, input logic z);
    res_t r;
    r.sum = s; r.c = c; r.o = o; r.z = z;
    return r;
  endfunction

  function automatic res_t obs32();
    return mk(bus32.sum_o, bus32.carry_o, bus32.overflow_o, bus32.zero_o);
  endfunction

  function automatic res_t obs8();
    return mk({24'b0, bus8.sum_o}, bus8.carry_o, bus8.overflow_o, bus8.zero_o);
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [32:0] full;
    logic [31:0] bx;
    res_t        r;
    bx    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bx} + {32'b0, sub};
    r.sum = full[31:0];
    r.c   = full[32];
    r.o   = (a[31] == bx[31]) && (full[31] != a[31]);
`ifdef PIPE_ADDER_SAT_EN
    if (r.o) r.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    r.z   = (r.sum == 32'h0);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_i && bus32.valid_o && bus32.ready_i) begin
      if (q32.size() == 0) check("sb32 underflow", q32.size(), 1);
      else check("res32", obs32(), q32.pop_front());
      if (n_pop32 == 0) first_pop32 = cyc;
      n_pop32++;
      last_pop32 = cyc;
    end
    if (!rst_i && bus8.valid_o && bus8.ready_i) begin
      if (q8.size() == 0) check("sb8 underflow", q8.size(), 1);
      else check("res8", obs8(), q8.pop_front());
      n_pop8++;
      last_pop8 = cyc;
    end
  end

  task automatic idle();
    bus32.valid_i = 1'b0; bus32.src1_i = '0; bus32.src2_i = '0; bus32.sub_i = 1'b0;
    bus8.valid_i  = 1'b0; bus8.src1_i  = '0; bus8.src2_i  = '0; bus8.sub_i  = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int sel, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input res_t exp);
    int n = 0;
    if (sel == 0) begin
      bus32.valid_i = 1'b1; bus32.src1_i = a; bus32.src2_i = b; bus32.sub_i = sub;
    end else begin
      bus8.valid_i = 1'b1; bus8.src1_i = a[7:0]; bus8.src2_i = b[7:0]; bus8.sub_i = sub;
    end
    forever begin
      @(negedge clk);
      if ((sel == 0) ? bus32.ready_o : bus8.ready_o) break;
      n++;
      if (n > 50) begin
        check("accept timeout", n, 0);
        return;
      end
    end
    last_acc = cyc;
    if (sel == 0) q32.push_back(exp);
    else q8.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q32.size() == 0 && q8.size() == 0) break;
    end
    check("drain32", q32.size(), 0);
    check("drain8", q8.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    res_t        held;
    idle();
    bus32.ready_i = 1'b1;
    bus8.ready_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst valid32", bus32.valid_o, 0);
    check("rst ready32", bus32.ready_o, 1);
    check("rst out32", obs32(), 0);
    check("rst out8", obs8(), 0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    check("post rst ready", bus32.ready_o, 1);

    send(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, mk(32'h0000_0100, 1'b0, 1'b0, 1'b0));
    idle();
    drain();
    check("latency32", last_pop32 - last_acc, 4);

    send(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    send(0, 32'h0000_0005, 32'h0000_0007, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    send(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(OVF_P32, 1'b0, 1'b1, 1'b0));
    send(0, 32'h8000_0000, 32'h0000_0001, 1'b1, mk(OVF_N32, 1'b1, 1'b1, 1'b0));
    idle();
    drain();

    n_pop32 = 0;
    for (int i = 0; i < 16; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      send(0, a, b, s, model(a, b, s));
    end
    idle();
    drain();
    check("stream count", n_pop32, 16);
    check("stream span", last_pop32 - first_pop32, 15);

    bus32.ready_i = 1'b0;
    n_pop32 = 0;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      send(0, a, b, s, model(a, b, s));
    end
    check("bp valid", bus32.valid_o, 1);
    held = obs32();
    bus32.valid_i = 1'b1; bus32.src1_i = 32'h1234_5678; bus32.src2_i = 32'h0BAD_F00D;
    repeat (5) begin
      @(negedge clk);
      check("bp ready", bus32.ready_o, 0);
      check("bp hold", obs32(), held);
    end
    @(posedge clk); #1;
    idle();
    bus32.ready_i = 1'b1;
    drain();
    check("bp count", n_pop32, 4);

    bus32.ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      send(0, a, b, 1'b0, model(a, b, 1'b0));
    end
    idle();
    check("pre rst valid", bus32.valid_o, 1);
    rst_i = 1'b1;
    #1;
    check("rst drop valid", bus32.valid_o, 0);
    check("rst drop sum", bus32.sum_o, 0);
    check("rst ready", bus32.ready_o, 1);
    q32.delete();
    @(posedge clk); #1;
    rst_i = 1'b0;
    bus32.ready_i = 1'b1;
    n_pop32 = 0;
    repeat (8) @(negedge clk);
    check("no stale", n_pop32, 0);
    @(posedge clk); #1;
    send(0, 32'h0000_0010, 32'h0000_0020, 1'b0, mk(32'h0000_0030, 1'b0, 1'b0, 1'b0));
    idle();
    drain();

    send(1, 32'h0000_000F, 32'h0000_0001, 1'b0, mk(32'h0000_0010, 1'b0, 1'b0, 1'b0));
    idle();
    drain();
    check("latency8", last_pop8 - last_acc, 1);
    send(1, 32'h0000_007F, 32'h0000_0001, 1'b0, mk(OVF_P8, 1'b0, 1'b1, 1'b0));
    send(1, 32'h0000_0003, 32'h0000_0003, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    idle();
    drain();
    check("count8", n_pop8, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
